// File: rtl/ng_tpg_sequencer.sv
// ng_tpg_sequencer: time pulse generator for the control pulse matrix.
// Steps the 12-pulse memory cycle (TP1..TP12) and handles power-on,
// standby and MCT/instruction single-step control. Emits the 4-bit TPG
// state code, a one-cycle MCT_END pulse after every TP12 exit and a
// wrapping count of completed MCTs.
// Optional feature: define NG_TPG_MEMWAIT_EN to let MEM_WAIT stretch TP6.
module ng_tpg_sequencer #(
   parameter  int unsigned MCT_W = 16,
   localparam int unsigned TPG_W = 4
) (
   input  logic             CLK2,
   input  logic             RESET,
   input  logic             STBY_REQ,
   input  logic             RUN,
   input  logic             INST,
   input  logic             STEP,
   input  logic             SNI,
   input  logic             MEM_WAIT,
   output logic [TPG_W-1:0] TPG,
   output logic             MCT_END,
   output logic [MCT_W-1:0] MCT_CNT
);

   // Encoding is shared with the CPM decoder and must not change.
   typedef enum logic [TPG_W-1:0] {
      ST_STBY  = 4'd0,
      ST_PWRON = 4'd1,
      ST_TP1   = 4'd2,
      ST_TP2   = 4'd3,
      ST_TP3   = 4'd4,
      ST_TP4   = 4'd5,
      ST_TP5   = 4'd6,
      ST_TP6   = 4'd7,
      ST_TP7   = 4'd8,
      ST_TP8   = 4'd9,
      ST_TP9   = 4'd10,
      ST_TP10  = 4'd11,
      ST_TP11  = 4'd12,
      ST_TP12  = 4'd13,
      ST_SRLSE = 4'd14,
      ST_WAIT  = 4'd15
   } tpg_state_e;

   tpg_state_e       state_q;
   tpg_state_e       state_d;
   logic             mct_end_q;
   logic             mct_end_d;
   logic [MCT_W-1:0] mct_cnt_q;
   logic [MCT_W-1:0] mct_cnt_d;
   logic             step_stop;

   // Step mode stops at every MCT end, or only at instruction end when INST=1.
   assign step_stop = !RUN && (!INST || SNI);

`ifndef NG_TPG_MEMWAIT_EN
   logic unused_mem_wait;
   assign unused_mem_wait = MEM_WAIT;
`endif

   // State and output registers; synchronous reset wins over everything.
   always_ff @(posedge CLK2) begin
      if (RESET) begin
         state_q   <= ST_STBY;
         mct_end_q <= 1'b0;
         mct_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mct_end_q <= mct_end_d;
         mct_cnt_q <= mct_cnt_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STBY:  state_d = STBY_REQ ? ST_STBY : ST_PWRON;
         ST_PWRON: state_d = RUN ? ST_TP1 : ST_SRLSE;
`ifdef NG_TPG_MEMWAIT_EN
         ST_TP6:   state_d = MEM_WAIT ? ST_TP6 : ST_TP7;
`else
         ST_TP6:   state_d = ST_TP7;
`endif
         ST_TP1, ST_TP2, ST_TP3, ST_TP4, ST_TP5,
         ST_TP7, ST_TP8, ST_TP9, ST_TP10, ST_TP11:
                   state_d = tpg_state_e'(state_q + TPG_W'(1));
         ST_TP12: begin
            if (STBY_REQ)       state_d = ST_STBY;
            else if (step_stop) state_d = ST_SRLSE;
            else                state_d = ST_TP1;
         end
         // Wait for button release so one press gives exactly one advance.
         ST_SRLSE: state_d = STEP ? ST_SRLSE : ST_WAIT;
         ST_WAIT: begin
            if (STBY_REQ)         state_d = ST_STBY;
            else if (STEP || RUN) state_d = ST_TP1;
            else                  state_d = ST_WAIT;
         end
         default:  state_d = ST_STBY;
      endcase
   end

   // Next values of the MCT_END pulse and MCT counter; TP12 always exits.
   always_comb begin
      mct_end_d = 1'b0;
      mct_cnt_d = mct_cnt_q;
      if (state_q == ST_TP12) begin
         mct_end_d = 1'b1;
         mct_cnt_d = mct_cnt_q + MCT_W'(1);
      end
   end

   assign TPG     = state_q;
   assign MCT_END = mct_end_q;
   assign MCT_CNT = mct_cnt_q;

endmodule

// File: tb/tb_ng_tpg_sequencer.sv
// Testbench for ng_tpg_sequencer: directed run-mode sequence plus
// randomized control inputs checked every cycle against a behavioural
// model of the pulse cycle (phase + pulse number + completed-MCT count).
module tb_ng_tpg_sequencer;

   localparam int unsigned MCT_W = 4;

   logic             CLK2 = 1'b0;
   logic             RESET;
   logic             STBY_REQ;
   logic             RUN;
   logic             INST;
   logic             STEP;
   logic             SNI;
   logic             MEM_WAIT;
   logic [3:0]       TPG;
   logic             MCT_END;
   logic [MCT_W-1:0] MCT_CNT;

   ng_tpg_sequencer #(.MCT_W(MCT_W)) dut (
      .CLK2     (CLK2),
      .RESET    (RESET),
      .STBY_REQ (STBY_REQ),
      .RUN      (RUN),
      .INST     (INST),
      .STEP     (STEP),
      .SNI      (SNI),
      .MEM_WAIT (MEM_WAIT),
      .TPG      (TPG),
      .MCT_END  (MCT_END),
      .MCT_CNT  (MCT_CNT)
   );

   always #5 CLK2 = ~CLK2;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: which phase the generator is in, and which pulse.
   localparam int PH_STBY = 0, PH_PWRON = 1, PH_CYCLE = 2, PH_RELEASE = 3, PH_WAIT = 4;
   int          m_phase = PH_STBY;
   int          m_pulse = 1;
   int unsigned m_cnt   = 0;
   bit          m_end   = 1'b0;

`ifdef NG_TPG_MEMWAIT_EN
   localparam bit MEMWAIT_EN = 1'b1;
`else
   localparam bit MEMWAIT_EN = 1'b0;
`endif

   function automatic int unsigned model_tpg();
      case (m_phase)
         PH_STBY:    return 0;
         PH_PWRON:   return 1;
         PH_CYCLE:   return 32'(m_pulse + 1);
         PH_RELEASE: return 14;
         default:    return 15;
      endcase
   endfunction

   // Advance the model by one clock using the inputs seen at that edge.
   task automatic model_step();
      m_end = 1'b0;
      if (RESET) begin
         m_phase = PH_STBY;
         m_cnt   = 0;
      end else begin
         case (m_phase)
            PH_STBY:  if (!STBY_REQ) m_phase = PH_PWRON;
            PH_PWRON: begin
               if (RUN) begin m_phase = PH_CYCLE; m_pulse = 1; end
               else m_phase = PH_RELEASE;
            end
            PH_CYCLE: begin
               if (m_pulse == 12) begin
                  m_end = 1'b1;
                  m_cnt = (m_cnt + 1) % (1 << MCT_W);
                  if (STBY_REQ) m_phase = PH_STBY;
                  else if (!RUN && (!INST || SNI)) m_phase = PH_RELEASE;
                  else m_pulse = 1;
               end else if (!(MEMWAIT_EN && m_pulse == 6 && MEM_WAIT)) begin
                  m_pulse++;
               end
            end
            PH_RELEASE: if (!STEP) m_phase = PH_WAIT;
            default: begin
               if (STBY_REQ) m_phase = PH_STBY;
               else if (STEP || RUN) begin m_phase = PH_CYCLE; m_pulse = 1; end
            end
         endcase
      end
   endtask

   // One clock: edge, model update, then compare all outputs just after the edge.
   task automatic tick_check();
      @(posedge CLK2);
      model_step();
      #1;
      check("tpg",     32'(TPG),     model_tpg());
      check("mct_end", 32'(MCT_END), 32'(m_end));
      check("mct_cnt", 32'(MCT_CNT), m_cnt);
   endtask

   initial begin
      RESET = 1'b1; STBY_REQ = 1'b0; RUN = 1'b1; INST = 1'b0;
      STEP = 1'b0; SNI = 1'b0; MEM_WAIT = 1'b0;

      // Directed run: reset, release, free-run; TPG 0,1,2..13,2..13,...
      tick_check();
      check("reset_tpg", 32'(TPG), 0);
      check("reset_cnt", 32'(MCT_CNT), 0);
      RESET = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick_check();
         check("run_seq_tpg", 32'(TPG), (k < 2) ? 32'(k) : 32'(2 + (k - 2) % 12));
         check("run_seq_end", 32'(MCT_END), (k >= 14 && (k - 14) % 12 == 0) ? 1 : 0);
         check("run_seq_cnt", 32'(MCT_CNT), (k < 14) ? 0 : 32'((k - 2) / 12));
      end

      // Standby requested mid-cycle: the cycle finishes before TPG drops to 0.
      STBY_REQ = 1'b1;
      for (int k = 0; k < 20; k++) tick_check();
      check("stby_hold", 32'(TPG), 0);
      STBY_REQ = 1'b0;
      tick_check();
      check("stby_pwron", 32'(TPG), 1);
      tick_check();
      check("stby_tp1", 32'(TPG), 2);

      // Randomized phases with different control biases.
      for (int ph = 0; ph < 6; ph++) begin
         for (int c = 0; c < 300; c++) begin
            RESET    = ($urandom_range(999) < 5);
            if ($urandom_range(99) < 3) STBY_REQ = ~STBY_REQ;
            if ($urandom_range(99) < 12) STEP = ~STEP;
            MEM_WAIT = ($urandom_range(99) < 40);
            SNI      = ($urandom_range(99) < 35);
            case (ph)
               0: begin RUN = 1'b1; INST = 1'b0; end
               1: begin RUN = 1'b0; INST = 1'b0; end
               2: begin RUN = 1'b0; INST = 1'b1; end
               3: begin RUN = 1'($urandom_range(1)); INST = 1'($urandom_range(1)); end
               4: begin RUN = 1'b1; INST = 1'b1; STBY_REQ = 1'b0; end
               default: begin RUN = ($urandom_range(99) < 10); INST = 1'($urandom_range(1)); end
            endcase
            tick_check();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
